// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_IF = 2'd1,
    WAIT_D  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arb_timer.sv
// Wait-state timeout counter for the memory arbiter.
// The count clears on entry to a wait state and advances on every wait
// cycle without a response. o_tc marks the cycle whose increment brings the
// count to TIMEOUT_CYCLES-1, so the abort response is registered on that
// same edge and a transaction never waits more than TIMEOUT_CYCLES-1 cycles.
module mem_arb_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tc
);

  localparam logic [7:0] TC_VAL = 8'(TIMEOUT_CYCLES - 2);

  logic [7:0] count;

  // Count wait cycles; a clear always wins over an increment.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      count <= 8'd0;
    end else if (i_clear) begin
      count <= 8'd0;
    end else if (i_enable) begin
      count <= count + 8'd1;
    end
  end

  assign o_tc = i_enable && (count == TC_VAL);

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (instruction fetch / data) arbiter onto a single memory port
// with one outstanding transaction and a wait-state timeout.
// Optional feature: define MEM_ARB_RR_EN for round-robin arbitration between
// simultaneous requests; otherwise data has fixed priority over IF.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_if_req,
  input  logic [DATA_W-1:0] i_if_addr,
  output logic              o_if_gnt,
  output logic              o_if_rvalid,
  output logic [DATA_W-1:0] o_if_rdata,
  output logic              o_if_err,
  input  logic              i_d_req,
  input  logic [DATA_W-1:0] i_d_addr,
  input  logic              i_d_we,
  input  logic [DATA_W-1:0] i_d_wdata,
  input  logic [DATA_W-1:0] i_d_wmask,
  output logic              o_d_gnt,
  output logic              o_d_rvalid,
  output logic [DATA_W-1:0] o_d_rdata,
  output logic              o_d_err,
  output logic              o_mem_req,
  output logic [DATA_W-1:0] o_mem_addr,
  output logic              o_mem_we,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic [DATA_W-1:0] o_mem_wmask,
  input  logic              i_mem_ready,
  input  logic              i_mem_rvalid,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_stray
);

  state_t state_q, state_d;
  owner_t winner;
  logic   prefer_d;
  logic   any_req;
  logic   accept;
  logic   waiting;
  logic   timeout;
  logic   resp_if, resp_d, resp_err, stray_d;

  assign any_req = i_if_req || i_d_req;
  assign waiting = (state_q != IDLE);
  assign accept  = (state_q == IDLE) && any_req && i_mem_ready;

`ifdef MEM_ARB_RR_EN
  owner_t last_owner;

  // Remember who won the most recent accept so a tie goes to the other side.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      last_owner <= OWN_IF;
    end else if (accept) begin
      last_owner <= winner;
    end
  end

  assign prefer_d = (last_owner == OWN_IF);
`else
  assign prefer_d = 1'b1;
`endif

  assign winner = (i_d_req && (!i_if_req || prefer_d)) ? OWN_D : OWN_IF;

  mem_arb_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (accept),
    .i_enable(waiting && !i_mem_rvalid),
    .o_tc    (timeout)
  );

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, memory-port drive, grants and response strobes.
  always_comb begin
    state_d     = state_q;
    o_mem_req   = 1'b0;
    o_mem_addr  = '0;
    o_mem_we    = 1'b0;
    o_mem_wdata = '0;
    o_mem_wmask = '0;
    o_if_gnt    = 1'b0;
    o_d_gnt     = 1'b0;
    resp_if     = 1'b0;
    resp_d      = 1'b0;
    resp_err    = 1'b0;
    stray_d     = 1'b0;
    case (state_q)
      IDLE: begin
        o_mem_req = any_req;
        stray_d   = i_mem_rvalid;
        if (any_req) begin
          if (winner == OWN_D) begin
            o_mem_addr  = i_d_addr;
            o_mem_we    = i_d_we;
            o_mem_wdata = i_d_wdata;
            o_mem_wmask = i_d_wmask;
          end else begin
            o_mem_addr  = i_if_addr;
          end
          if (i_mem_ready) begin
            if (winner == OWN_D) begin
              o_d_gnt = 1'b1;
              state_d = WAIT_D;
            end else begin
              o_if_gnt = 1'b1;
              state_d  = WAIT_IF;
            end
          end
        end
      end
      WAIT_IF: begin
        if (i_mem_rvalid || timeout) begin
          resp_if  = 1'b1;
          resp_err = !i_mem_rvalid;
          state_d  = IDLE;
        end
      end
      WAIT_D: begin
        if (i_mem_rvalid || timeout) begin
          resp_d   = 1'b1;
          resp_err = !i_mem_rvalid;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered responses; data is forced to zero on errors and idle cycles.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_if_rvalid <= 1'b0;
      o_if_rdata  <= '0;
      o_if_err    <= 1'b0;
      o_d_rvalid  <= 1'b0;
      o_d_rdata   <= '0;
      o_d_err     <= 1'b0;
      o_stray     <= 1'b0;
    end else begin
      o_if_rvalid <= resp_if;
      o_if_rdata  <= (resp_if && !resp_err) ? i_mem_rdata : '0;
      o_if_err    <= resp_if && resp_err;
      o_d_rvalid  <= resp_d;
      o_d_rdata   <= (resp_d && !resp_err) ? i_mem_rdata : '0;
      o_d_err     <= resp_d && resp_err;
      o_stray     <= stray_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_mem_arbiter;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 0, d_req = 0, d_we = 0;
  logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0, d_wmask = 0;
  logic        mem_ready = 0, mem_rvalid = 0;
  logic [31:0] mem_rdata = 0;
  logic        if_gnt, if_rvalid, if_err, d_gnt, d_rvalid, d_err;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_wmask;
  logic        mem_req, mem_we, stray;

  int n_checks = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_if_req(if_req), .i_if_addr(if_addr),
    .o_if_gnt(if_gnt), .o_if_rvalid(if_rvalid), .o_if_rdata(if_rdata), .o_if_err(if_err),
    .i_d_req(d_req), .i_d_addr(d_addr), .i_d_we(d_we), .i_d_wdata(d_wdata), .i_d_wmask(d_wmask),
    .o_d_gnt(d_gnt), .o_d_rvalid(d_rvalid), .o_d_rdata(d_rdata), .o_d_err(d_err),
    .o_mem_req(mem_req), .o_mem_addr(mem_addr), .o_mem_we(mem_we),
    .o_mem_wdata(mem_wdata), .o_mem_wmask(mem_wmask),
    .i_mem_ready(mem_ready), .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata),
    .o_stray(stray)
  );

  function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endfunction

  // ---------------- transaction-level model ----------------
  bit        m_busy, m_owner_d, m_last_d;
  int        m_wait;
  bit        m_acc_if, m_acc_d;
  bit        e_if_rvalid, e_if_err, e_d_rvalid, e_d_err, e_stray;
  bit [31:0] e_if_rdata, e_d_rdata;
  bit        e_mem_req, e_win_d;

  // Who would win right now, from the arbitration rules.
  always_comb begin
    e_mem_req = !m_busy && (if_req || d_req);
`ifdef MEM_ARB_RR_EN
    e_win_d = d_req && (!if_req || !m_last_d);
`else
    e_win_d = d_req;
`endif
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 0; m_owner_d <= 0; m_last_d <= 0; m_wait <= 0;
      m_acc_if <= 0; m_acc_d <= 0;
      e_if_rvalid <= 0; e_if_err <= 0; e_if_rdata <= 0;
      e_d_rvalid <= 0; e_d_err <= 0; e_d_rdata <= 0; e_stray <= 0;
    end else begin
      m_acc_if <= 0; m_acc_d <= 0;
      e_if_rvalid <= 0; e_if_err <= 0; e_if_rdata <= 0;
      e_d_rvalid <= 0; e_d_err <= 0; e_d_rdata <= 0; e_stray <= 0;
      if (!m_busy) begin
        if (mem_rvalid) e_stray <= 1;
        if (e_mem_req && mem_ready) begin
          m_busy <= 1; m_owner_d <= e_win_d; m_last_d <= e_win_d; m_wait <= 1;
          if (e_win_d) m_acc_d <= 1; else m_acc_if <= 1;
        end
      end else if (mem_rvalid || m_wait == T - 1) begin
        // A response completes the wait; otherwise the (T-1)th silent
        // wait cycle aborts it with an error.
        m_busy <= 0;
        if (m_owner_d) begin
          e_d_rvalid <= 1; e_d_err <= !mem_rvalid; e_d_rdata <= mem_rvalid ? mem_rdata : 0;
        end else begin
          e_if_rvalid <= 1; e_if_err <= !mem_rvalid; e_if_rdata <= mem_rvalid ? mem_rdata : 0;
        end
      end else begin
        m_wait <= m_wait + 1;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("mem_req", 32'(mem_req), 32'(e_mem_req));
    chk("if_gnt", 32'(if_gnt), 32'(e_mem_req && mem_ready && !e_win_d));
    chk("d_gnt", 32'(d_gnt), 32'(e_mem_req && mem_ready && e_win_d));
    if (e_mem_req) begin
      chk("mem_addr", mem_addr, e_win_d ? d_addr : if_addr);
      chk("mem_we", 32'(mem_we), e_win_d ? 32'(d_we) : 32'd0);
      chk("mem_wdata", mem_wdata, e_win_d ? d_wdata : 32'd0);
      chk("mem_wmask", mem_wmask, e_win_d ? d_wmask : 32'd0);
    end
    chk("if_rvalid", 32'(if_rvalid), 32'(e_if_rvalid));
    chk("if_rdata", if_rdata, e_if_rdata);
    chk("if_err", 32'(if_err), 32'(e_if_err));
    chk("d_rvalid", 32'(d_rvalid), 32'(e_d_rvalid));
    chk("d_rdata", d_rdata, e_d_rdata);
    chk("d_err", 32'(d_err), 32'(e_d_err));
    chk("stray", 32'(stray), 32'(e_stray));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    step(); step();
    rst = 0;

    // IF-only read.
    if_req = 1; if_addr = 32'h8000_0000; mem_ready = 1;
    settle();
    chk("lit_if_gnt", 32'(if_gnt), 1);
    chk("lit_if_addr", mem_addr, 32'h8000_0000);
    step();
    if_req = 0; mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h0000_0013;
    settle();
    chk("lit_if_rvalid_early", 32'(if_rvalid), 0);
    step();
    mem_rvalid = 0; mem_rdata = 0;
    settle();
    chk("lit_if_rvalid", 32'(if_rvalid), 1);
    chk("lit_if_rdata", if_rdata, 32'h0000_0013);
    chk("lit_if_err", 32'(if_err), 0);

    // Simultaneous requests: data first, IF at the next idle cycle.
    step();
    if_req = 1; if_addr = 32'h8000_0004; d_req = 1; d_addr = 32'h100; mem_ready = 1;
    settle();
    chk("lit_sim_d_gnt", 32'(d_gnt), 1);
    chk("lit_sim_if_gnt0", 32'(if_gnt), 0);
    chk("lit_sim_addr", mem_addr, 32'h100);
    step();
    d_req = 0; mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF;
    settle();
    chk("lit_sim_wait_req", 32'(mem_req), 0);
    step();
    mem_rvalid = 0;
    settle();
    chk("lit_sim_d_rvalid", 32'(d_rvalid), 1);
    chk("lit_sim_if_gnt", 32'(if_gnt), 1);
    chk("lit_sim_if_addr", mem_addr, 32'h8000_0004);
    step();
    if_req = 0; mem_ready = 0; mem_rvalid = 1;
    step();
    mem_rvalid = 0;

    // Timeout on a data write, then a late response is flagged as stray.
    d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'h1234_5678; d_wmask = 32'hFFFF_FFFF;
    mem_ready = 1;
    settle();
    chk("lit_to_gnt", 32'(d_gnt), 1);
    chk("lit_to_we", 32'(mem_we), 1);
    step();
    d_req = 0; d_we = 0; mem_ready = 0;
    for (int i = 1; i < T; i++) begin
      settle();
      chk("lit_to_quiet", 32'(d_rvalid), 0);
      step();
    end
    settle();
    chk("lit_to_rvalid", 32'(d_rvalid), 1);
    chk("lit_to_err", 32'(d_err), 1);
    chk("lit_to_rdata", d_rdata, 0);
    mem_rvalid = 1; mem_rdata = 32'h5555_5555;
    step();
    mem_rvalid = 0;
    settle();
    chk("lit_to_stray", 32'(stray), 1);
    chk("lit_to_no_resp", 32'(d_rvalid), 0);

    // Backpressure: no grant while ready is low.
    step();
    if_req = 1; if_addr = 32'h8000_0100; mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("lit_bp_nognt", 32'(if_gnt), 0);
      chk("lit_bp_req", 32'(mem_req), 1);
      step();
    end
    mem_ready = 1;
    settle();
    chk("lit_bp_gnt", 32'(if_gnt), 1);
    step();
    if_req = 0; mem_ready = 0; mem_rvalid = 1;
    step();
    mem_rvalid = 0;
    step();

    // Reset during WAIT_D drops the transaction silently.
    d_req = 1; d_addr = 32'h300; mem_ready = 1;
    step();
    d_req = 0; mem_ready = 0;
    rst = 1;
    settle();
    chk("lit_rst_req", 32'(mem_req), 0);
    chk("lit_rst_rv", 32'(d_rvalid | if_rvalid | stray), 0);
    step();
    rst = 0; mem_rvalid = 1;
    step();
    mem_rvalid = 0;
    settle();
    chk("lit_rst_stray", 32'(stray), 1);
    chk("lit_rst_nodv", 32'(d_rvalid), 0);
    step();

    // Randomized traffic obeying the hold-until-grant protocol.
    for (int c = 0; c < 4000; c++) begin
      if (m_acc_if || !if_req || $urandom_range(0, 99) < 4) begin
        if_req = ($urandom_range(0, 99) < 40) && !(if_req && !m_acc_if);
        if_addr = $urandom;
      end
      if (m_acc_d || !d_req || $urandom_range(0, 99) < 4) begin
        d_req = ($urandom_range(0, 99) < 40) && !(d_req && !m_acc_d);
        d_addr = $urandom; d_we = 1'($urandom); d_wdata = $urandom; d_wmask = $urandom;
      end
      mem_ready  = ($urandom_range(0, 99) < 70);
      mem_rvalid = m_busy ? ($urandom_range(0, 99) < 35) : ($urandom_range(0, 99) < 5);
      mem_rdata  = $urandom;
      if (c % 997 == 500) rst = 1;
      else rst = 0;
      step();
    end
    rst = 0; if_req = 0; d_req = 0; mem_rvalid = 0; mem_ready = 0;
    repeat (T + 2) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
